// File: rtl/avalon_ram_responder.sv
// Word-organised RAM acting as the responder on an Avalon-MM style bus.
// Programmable wait states, byte-enabled writes, and a sticky protocol/range error flag.
module avalon_ram_responder #(
    parameter int unsigned ADDR_W      = 10,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] address,
    input  logic        read,
    input  logic        write,
    input  logic [3:0]  byteenable,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        waitrequest,
    output logic        bus_err
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCEPT = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                init_q;
    logic [ADDR_W-1:0]   idx_q;
    logic [3:0]          be_q;
    logic [31:0]         wdata_q;
    logic                wr_q;
    logic                rerr_q;
    logic                bus_err_q;
    logic [31:0]         rdata_q;
    logic [31:0]         mem_q [DEPTH];

    logic [31:0]         offset_c;
    logic [ADDR_W-1:0]   idx_c;
    logic                range_err_c;
    logic                req_c;
    logic                accept_c;
    logic                to_accept_c;

    // Byte offset from the window base, wrap-around unsigned
    assign offset_c    = address - BASE_ADDR;
    assign idx_c       = ADDR_W'(offset_c >> 2);
    assign range_err_c = (address < BASE_ADDR) || ((offset_c >> (ADDR_W + 2)) != 32'd0);
    assign req_c       = read | write;
    assign accept_c    = (state_q == ST_IDLE) && !init_q && req_c;
    assign to_accept_c = (state_q == ST_WAIT) && (state_d == ST_ACCEPT);

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            init_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            init_q  <= 1'b0;
        end
    end

    // Next-state logic; dropping the request during WAIT aborts the access
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    state_d = ST_WAIT;
                    cnt_d   = CNT_W'(WAIT_CYCLES);
                end
            end
            ST_WAIT: begin
                if (!req_c) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == '0) begin
                    state_d = ST_ACCEPT;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_ACCEPT: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Output logic; the first cycle after reset release still stalls
    always_comb begin
        waitrequest = 1'b0;
        case (state_q)
            ST_IDLE:   waitrequest = init_q | req_c;
            ST_WAIT:   waitrequest = 1'b1;
            ST_ACCEPT: waitrequest = 1'b0;
            default:   waitrequest = 1'b1;
        endcase
    end

    // Request latch, sticky error flag and registered read data
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx_q     <= '0;
            be_q      <= '0;
            wdata_q   <= '0;
            wr_q      <= 1'b0;
            rerr_q    <= 1'b0;
            bus_err_q <= 1'b0;
            rdata_q   <= '0;
        end else begin
            if (accept_c) begin
                idx_q     <= idx_c;
                be_q      <= byteenable;
                wdata_q   <= writedata;
                wr_q      <= write & ~read;
                rerr_q    <= range_err_c;
                bus_err_q <= bus_err_q | range_err_c | (address[1:0] != 2'b00) | (read & write);
            end
            if (to_accept_c && !wr_q) begin
                rdata_q <= rerr_q ? 32'h0 : mem_q[idx_q];
            end
        end
    end

    // Storage is not reset; writes land on the edge that closes ACCEPT
    always_ff @(posedge clk) begin
        if (state_q == ST_ACCEPT && wr_q && !rerr_q) begin
            for (int i = 0; i < 4; i++) begin
                if (be_q[i]) begin
                    mem_q[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

    assign readdata = rdata_q;
    assign bus_err  = bus_err_q;

endmodule
